// File: rtl/triangle_assembler.sv
// Groups the serial x,y,z,w component stream into triangles, computes signed 2x area,
// clamped bbox and cull decision, and hands survivors to a 1-entry valid/ready register.
module triangle_assembler #(
  parameter int M             = 11,
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int CULL_BACKFACE = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [M-1:0]     in_comp,
  input  logic             in_comp_valid,
  output logic             tri_valid,
  input  logic             tri_ready,
  output logic [M-1:0]     tri_x0,
  output logic [M-1:0]     tri_x1,
  output logic [M-1:0]     tri_x2,
  output logic [M-1:0]     tri_y0,
  output logic [M-1:0]     tri_y1,
  output logic [M-1:0]     tri_y2,
  output logic [M-1:0]     tri_z0,
  output logic [M-1:0]     tri_z1,
  output logic [M-1:0]     tri_z2,
  output logic [M-1:0]     bbox_xmin,
  output logic [M-1:0]     bbox_xmax,
  output logic [M-1:0]     bbox_ymin,
  output logic [M-1:0]     bbox_ymax,
  output logic [2*M+2:0]   tri_area,
  output logic [CNT_W-1:0] cull_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  localparam int AW = 2*M + 3;
  localparam logic signed [M:0] XLIM = (M+1)'(SCREEN_W - 1);
  localparam logic signed [M:0] YLIM = (M+1)'(SCREEN_H - 1);

  logic [1:0] comp_cnt_reg, vert_cnt_reg, eff_comp, eff_vert;
  logic       last_beat;
  logic signed [M-1:0] vx[3], vy[3], vz[3];

  logic s0_valid_reg, s1_valid_reg, s2_valid_reg;
  logic signed [M-1:0] s1_x[3], s1_y[3], s1_z[3];
  logic signed [M:0]   s1_dx1, s1_dy1, s1_dx2, s1_dy2;
  logic signed [M-1:0] s1_xmin, s1_xmax, s1_ymin, s1_ymax;
  logic signed [2*M+1:0] s2_p0, s2_p1;
  logic [M-1:0] s2_bxmin, s2_bxmax, s2_bymin, s2_bymax;
  logic         s2_off;

  logic signed [AW-1:0] area_c;
  logic cull_c, load_c;

  function automatic logic signed [M-1:0] min3(input logic signed [M-1:0] a, b, c);
    logic signed [M-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [M-1:0] max3(input logic signed [M-1:0] a, b, c);
    logic signed [M-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [M-1:0] clamp(input logic signed [M-1:0] v, input logic signed [M:0] hi);
    if (v[M-1]) return '0;
    else if ($signed({v[M-1], v}) > hi) return hi[M-1:0];
    else return v;
  endfunction

  // frame_start makes a coincident beat land as vertex0.x
  always_comb begin
    eff_comp  = frame_start ? 2'd0 : comp_cnt_reg;
    eff_vert  = frame_start ? 2'd0 : vert_cnt_reg;
    last_beat = in_comp_valid && (eff_comp == 2'd3) && (eff_vert == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      comp_cnt_reg <= '0;
      vert_cnt_reg <= '0;
      s0_valid_reg <= 1'b0;
    end else begin
      s0_valid_reg <= last_beat;
      if (in_comp_valid) begin
        comp_cnt_reg <= eff_comp + 2'd1;
        if (eff_comp == 2'd3)
          vert_cnt_reg <= (eff_vert == 2'd2) ? 2'd0 : eff_vert + 2'd1;
        else
          vert_cnt_reg <= eff_vert;
      end else if (frame_start) begin
        comp_cnt_reg <= '0;
        vert_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_comp_valid) begin
      case (eff_comp)
        2'd0:    vx[eff_vert] <= in_comp;
        2'd1:    vy[eff_vert] <= in_comp;
        2'd2:    vz[eff_vert] <= in_comp;
        default: ;
      endcase
    end
  end

  // Vertex copies taken at E0+1 stay put until the next triangle completes 12 beats later
  always_ff @(posedge clk) begin
    if (s0_valid_reg) begin
      for (int i = 0; i < 3; i++) begin
        s1_x[i] <= vx[i];
        s1_y[i] <= vy[i];
        s1_z[i] <= vz[i];
      end
      s1_dx1  <= {vx[1][M-1], vx[1]} - {vx[0][M-1], vx[0]};
      s1_dy1  <= {vy[1][M-1], vy[1]} - {vy[0][M-1], vy[0]};
      s1_dx2  <= {vx[2][M-1], vx[2]} - {vx[0][M-1], vx[0]};
      s1_dy2  <= {vy[2][M-1], vy[2]} - {vy[0][M-1], vy[0]};
      s1_xmin <= min3(vx[0], vx[1], vx[2]);
      s1_xmax <= max3(vx[0], vx[1], vx[2]);
      s1_ymin <= min3(vy[0], vy[1], vy[2]);
      s1_ymax <= max3(vy[0], vy[1], vy[2]);
    end
    if (s1_valid_reg) begin
      s2_p0    <= s1_dx1 * s1_dy2;
      s2_p1    <= s1_dx2 * s1_dy1;
      s2_bxmin <= clamp(s1_xmin, XLIM);
      s2_bxmax <= clamp(s1_xmax, XLIM);
      s2_bymin <= clamp(s1_ymin, YLIM);
      s2_bymax <= clamp(s1_ymax, YLIM);
      s2_off   <= s1_xmax[M-1] | s1_ymax[M-1] |
                  ($signed({s1_xmin[M-1], s1_xmin}) > XLIM) |
                  ($signed({s1_ymin[M-1], s1_ymin}) > YLIM);
    end
  end

  always_comb begin
    area_c = {s2_p0[2*M+1], s2_p0} - {s2_p1[2*M+1], s2_p1};
    cull_c = (area_c == '0) || s2_off || ((CULL_BACKFACE != 0) && area_c[AW-1]);
    load_c = s2_valid_reg && !cull_c && (!tri_valid || tri_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      tri_valid    <= 1'b0;
      overflow     <= 1'b0;
      cull_count   <= '0;
      drop_count   <= '0;
      tri_x0 <= '0; tri_x1 <= '0; tri_x2 <= '0;
      tri_y0 <= '0; tri_y1 <= '0; tri_y2 <= '0;
      tri_z0 <= '0; tri_z1 <= '0; tri_z2 <= '0;
      bbox_xmin <= '0; bbox_xmax <= '0; bbox_ymin <= '0; bbox_ymax <= '0;
      tri_area  <= '0;
    end else begin
      s1_valid_reg <= s0_valid_reg;
      s2_valid_reg <= s1_valid_reg;
      overflow     <= s2_valid_reg && !cull_c && !load_c;
      if (s2_valid_reg && cull_c && (cull_count != {CNT_W{1'b1}}))
        cull_count <= cull_count + CNT_W'(1);
      if (s2_valid_reg && !cull_c && !load_c && (drop_count != {CNT_W{1'b1}}))
        drop_count <= drop_count + CNT_W'(1);
      if (load_c) begin
        tri_valid <= 1'b1;
        tri_x0 <= s1_x[0]; tri_x1 <= s1_x[1]; tri_x2 <= s1_x[2];
        tri_y0 <= s1_y[0]; tri_y1 <= s1_y[1]; tri_y2 <= s1_y[2];
        tri_z0 <= s1_z[0]; tri_z1 <= s1_z[1]; tri_z2 <= s1_z[2];
        bbox_xmin <= s2_bxmin; bbox_xmax <= s2_bxmax;
        bbox_ymin <= s2_bymin; bbox_ymax <= s2_bymax;
        tri_area  <= area_c;
      end else if (tri_ready) begin
        tri_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_triangle_assembler.sv
// Scoreboard bench: two instances (back-face culling on/off) fed the same component stream.
module tb_triangle_assembler;
  localparam int M = 11;

  logic clk = 1'b0;
  logic reset, frame_start, in_comp_valid, tri_ready;
  logic [M-1:0] in_comp;

  logic a_valid, a_ovf, b_valid, b_ovf;
  logic [M-1:0] a_x0, a_x1, a_x2, a_y0, a_y1, a_y2, a_z0, a_z1, a_z2;
  logic [M-1:0] a_bxmin, a_bxmax, a_bymin, a_bymax;
  logic [M-1:0] b_x0, b_x1, b_x2, b_y0, b_y1, b_y2, b_z0, b_z1, b_z2;
  logic [M-1:0] b_bxmin, b_bxmax, b_bymin, b_bymax;
  logic [2*M+2:0] a_area, b_area;
  logic [15:0] a_cull, a_drop, b_cull, b_drop;

  typedef struct packed {
    logic [M-1:0] x0, y0, z0, x1, y1, z1, x2, y2, z2;
    logic [M-1:0] bxmin, bxmax, bymin, bymax;
    logic [2*M+2:0] area;
  } tri_t;

  tri_t obs_a, obs_b, held_a, held_b;
  bit held_a_v, held_b_v;
  tri_t qa[$], qb[$];
  int checks = 0, failures = 0;
  int exp_cull_a = 0, exp_cull_b = 0, exp_drop = 0, ovf_a = 0, ovf_b = 0;
  bit rnd_ready = 0;
  bit fs_pending = 0;

  assign obs_a = {a_x0, a_y0, a_z0, a_x1, a_y1, a_z1, a_x2, a_y2, a_z2,
                  a_bxmin, a_bxmax, a_bymin, a_bymax, a_area};
  assign obs_b = {b_x0, b_y0, b_z0, b_x1, b_y1, b_z1, b_x2, b_y2, b_z2,
                  b_bxmin, b_bxmax, b_bymin, b_bymax, b_area};

  triangle_assembler #(.CULL_BACKFACE(1)) dut_a (
    .clk(clk), .reset(reset), .frame_start(frame_start), .in_comp(in_comp),
    .in_comp_valid(in_comp_valid), .tri_valid(a_valid), .tri_ready(tri_ready),
    .tri_x0(a_x0), .tri_x1(a_x1), .tri_x2(a_x2), .tri_y0(a_y0), .tri_y1(a_y1), .tri_y2(a_y2),
    .tri_z0(a_z0), .tri_z1(a_z1), .tri_z2(a_z2),
    .bbox_xmin(a_bxmin), .bbox_xmax(a_bxmax), .bbox_ymin(a_bymin), .bbox_ymax(a_bymax),
    .tri_area(a_area), .cull_count(a_cull), .drop_count(a_drop), .overflow(a_ovf));

  triangle_assembler #(.CULL_BACKFACE(0)) dut_b (
    .clk(clk), .reset(reset), .frame_start(frame_start), .in_comp(in_comp),
    .in_comp_valid(in_comp_valid), .tri_valid(b_valid), .tri_ready(tri_ready),
    .tri_x0(b_x0), .tri_x1(b_x1), .tri_x2(b_x2), .tri_y0(b_y0), .tri_y1(b_y1), .tri_y2(b_y2),
    .tri_z0(b_z0), .tri_z1(b_z1), .tri_z2(b_z2),
    .bbox_xmin(b_bxmin), .bbox_xmax(b_bxmax), .bbox_ymin(b_bymin), .bbox_ymax(b_bymax),
    .tri_area(b_area), .cull_count(b_cull), .drop_count(b_drop), .overflow(b_ovf));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int clampv(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic tri_t model(input int x0, y0, z0, x1, y1, z1, x2, y2, z2,
                                 output longint area, output bit off);
    tri_t t;
    int xmin, xmax, ymin, ymax;
    area = longint'(x1 - x0) * (y2 - y0) - longint'(x2 - x0) * (y1 - y0);
    xmin = (x0 < x1 ? x0 : x1); xmin = (x2 < xmin ? x2 : xmin);
    xmax = (x0 > x1 ? x0 : x1); xmax = (x2 > xmax ? x2 : xmax);
    ymin = (y0 < y1 ? y0 : y1); ymin = (y2 < ymin ? y2 : ymin);
    ymax = (y0 > y1 ? y0 : y1); ymax = (y2 > ymax ? y2 : ymax);
    off = (xmax < 0) || (ymax < 0) || (xmin > 639) || (ymin > 479);
    t.x0 = x0[M-1:0]; t.y0 = y0[M-1:0]; t.z0 = z0[M-1:0];
    t.x1 = x1[M-1:0]; t.y1 = y1[M-1:0]; t.z1 = z1[M-1:0];
    t.x2 = x2[M-1:0]; t.y2 = y2[M-1:0]; t.z2 = z2[M-1:0];
    t.bxmin = M'(clampv(xmin, 639)); t.bxmax = M'(clampv(xmax, 639));
    t.bymin = M'(clampv(ymin, 479)); t.bymax = M'(clampv(ymax, 479));
    t.area  = area[2*M+2:0];
    return t;
  endfunction

  task automatic beat(input int v);
    in_comp = v[M-1:0];
    in_comp_valid = 1'b1;
    frame_start = fs_pending;
    fs_pending = 0;
    @(posedge clk); #1;
    in_comp_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_vert(input int x, y, z, input bit gaps);
    int c[4];
    c[0] = x; c[1] = y; c[2] = z; c[3] = int'($urandom_range(0, 2047));
    for (int k = 0; k < 4; k++) begin
      beat(c[k]);
      if (gaps && k < 3 && $urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
  endtask

  task automatic send_tri(input int x0, y0, z0, x1, y1, z1, x2, y2, z2,
                          input bit gaps, input bit drop);
    tri_t t;
    longint area;
    bit off;
    t = model(x0, y0, z0, x1, y1, z1, x2, y2, z2, area, off);
    if (area == 0 || off || area < 0) exp_cull_a++;
    else if (drop) exp_drop++;
    else qa.push_back(t);
    if (area == 0 || off) exp_cull_b++;
    else if (!drop) qb.push_back(t);
    send_vert(x0, y0, z0, gaps);
    send_vert(x1, y1, z1, gaps);
    send_vert(x2, y2, z2, gaps);
  endtask

  task automatic do_reset;
    reset = 1'b1; in_comp_valid = 1'b0; frame_start = 1'b0;
    idle(2);
    reset = 1'b0;
    qa.delete(); qb.delete();
    exp_cull_a = 0; exp_cull_b = 0; exp_drop = 0; ovf_a = 0; ovf_b = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((qa.size() + qb.size()) != 0 && n < 200) begin idle(1); n++; end
    chk(name, 200'(qa.size() + qb.size()), 200'(0));
    idle(6);
  endtask

  // Monitor: pops one expected triangle per handshake and checks held outputs stay stable
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        held_a_v = 0; held_b_v = 0;
      end else begin
        if (a_ovf) ovf_a++;
        if (b_ovf) ovf_b++;
        if (a_valid) begin
          if (held_a_v) chk("hold_a", 200'(obs_a), 200'(held_a));
          if (tri_ready) begin
            held_a_v = 0;
            if (qa.size() == 0) begin
              checks++; failures++;
              $display("FAIL tri_a actual=%0h expected=none", obs_a);
            end else chk("tri_a", 200'(obs_a), 200'(qa.pop_front()));
          end else begin held_a = obs_a; held_a_v = 1; end
        end else held_a_v = 0;
        if (b_valid) begin
          if (held_b_v) chk("hold_b", 200'(obs_b), 200'(held_b));
          if (tri_ready) begin
            held_b_v = 0;
            if (qb.size() == 0) begin
              checks++; failures++;
              $display("FAIL tri_b actual=%0h expected=none", obs_b);
            end else chk("tri_b", 200'(obs_b), 200'(qb.pop_front()));
          end else begin held_b = obs_b; held_b_v = 1; end
        end else held_b_v = 0;
      end
    end
  end

  // Ready is high at least every 4th cycle so random traffic never overflows the output
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rnd_ready) tri_ready = (cyc % 4 == 0) || ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    tri_ready = 1'b1; in_comp = '0; in_comp_valid = 1'b0; frame_start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    do_reset();
    chk("reset_a", 200'({a_valid, obs_a, a_cull, a_drop, a_ovf}), 200'(0));
    chk("reset_b", 200'({b_valid, obs_b, b_cull, b_drop, b_ovf}), 200'(0));

    // CCW right triangle and latency
    send_tri(0, 0, 0, 10, 0, 0, 0, 10, 0, 0, 0);
    idle(2);
    chk("latency3", 200'(a_valid), 200'(0));
    idle(1);
    chk("latency4", 200'(a_valid), 200'(1));
    drain("drain_basic");

    send_tri(0, 0, 0, 0, 10, 0, 10, 0, 0, 0, 0);     // clockwise
    send_tri(0, 0, 1, 5, 5, 2, 10, 10, 3, 1, 0);     // degenerate
    send_tri(-50, 0, 0, -30, 0, 0, -40, 10, 0, 0, 0); // off-screen left
    send_tri(-20, -5, 7, 700, 0, 8, 10, 500, 9, 1, 0); // clamped bbox
    drain("drain_directed");
    chk("cull_a_dir", 200'(a_cull), 200'(exp_cull_a));
    chk("cull_b_dir", 200'(b_cull), 200'(exp_cull_b));

    // Full output register: first held, second dropped
    tri_ready = 1'b0;
    send_tri(0, 0, 1, 20, 0, 2, 0, 20, 3, 0, 0);
    send_tri(5, 5, 4, 30, 5, 5, 5, 30, 6, 0, 1);
    idle(8);
    tri_ready = 1'b1;
    drain("drain_drop");
    chk("drop_a", 200'(a_drop), 200'(exp_drop));
    chk("drop_b", 200'(b_drop), 200'(exp_drop));
    chk("ovf_a", 200'(ovf_a), 200'(exp_drop));
    chk("ovf_b", 200'(ovf_b), 200'(exp_drop));

    // Resync: stray beats, then a standalone pulse; then a pulse coincident with vertex0.x
    for (int k = 0; k < 5; k++) beat(100 + k);
    frame_start = 1'b1; idle(1); frame_start = 1'b0;
    send_tri(100, 100, 1, 200, 100, 2, 100, 200, 3, 0, 0);
    for (int k = 0; k < 3; k++) beat(300 + k);
    fs_pending = 1;
    send_tri(50, 60, 1, 90, 60, 2, 50, 90, 3, 1, 0);
    drain("drain_resync");

    // Randomized traffic with random ready
    rnd_ready = 1;
    for (int n = 0; n < 40; n++) begin
      int c[9];
      for (int k = 0; k < 9; k++)
        c[k] = (k % 3 == 2) ? int'($urandom_range(0, 2047)) - 1024
             : (k % 3 == 0) ? int'($urandom_range(0, 1300)) - 300
             :                int'($urandom_range(0, 1000)) - 300;
      send_tri(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], c[8], 1, 0);
    end
    rnd_ready = 0;
    tri_ready = 1'b1;
    drain("drain_random");
    chk("cull_a_rnd", 200'(a_cull), 200'(exp_cull_a));
    chk("cull_b_rnd", 200'(b_cull), 200'(exp_cull_b));
    chk("drop_a_rnd", 200'(a_drop), 200'(exp_drop));
    chk("ovf_a_rnd", 200'(ovf_a), 200'(exp_drop));

    // Reset with a triangle in flight, then reset mid-triangle
    for (int k = 0; k < 12; k++) beat((k % 4 == 0) ? 10 * (k / 4) : ((k == 9) ? 40 : 0));
    idle(1);
    do_reset();
    for (int k = 0; k < 7; k++) beat(k);
    do_reset();
    idle(8);
    chk("reset_mid_a", 200'({a_valid, obs_a, a_cull, a_drop, a_ovf}), 200'(0));
    chk("reset_mid_b", 200'({b_valid, obs_b, b_cull, b_drop, b_ovf}), 200'(0));
    send_tri(1, 2, 3, 40, 2, 4, 1, 40, 5, 0, 0);
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
